// File: rtl/speed_msg_encoder_pkg.sv
// Shared definitions for the speed message encoder and the display decoder:
// message-code nibbles, FSM state encoding and the status classifier.
package speed_msg_encoder_pkg;

  // Digit codes are the BCD value itself.
  localparam logic [3:0] CODE_0     = 4'h0;
  localparam logic [3:0] CODE_1     = 4'h1;
  localparam logic [3:0] CODE_2     = 4'h2;
  localparam logic [3:0] CODE_3     = 4'h3;
  localparam logic [3:0] CODE_4     = 4'h4;
  localparam logic [3:0] CODE_5     = 4'h5;
  localparam logic [3:0] CODE_6     = 4'h6;
  localparam logic [3:0] CODE_7     = 4'h7;
  localparam logic [3:0] CODE_8     = 4'h8;
  localparam logic [3:0] CODE_9     = 4'h9;
  // Status codes; each is sent in both nibbles.
  localparam logic [3:0] CODE_EMPTY = 4'hA;
  localparam logic [3:0] CODE_HIGH  = 4'hB;
  localparam logic [3:0] CODE_LOW   = 4'hC;
  localparam logic [3:0] CODE_FREQ  = 4'hD;
  localparam logic [3:0] CODE_ERROR = 4'hE;

  // FSM state encoding.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CONV  = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_PULSE = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  // Measurement qualifier flags that travel with a speed sample.
  typedef struct packed {
    logic err;
    logic freq;
    logic no_tgt;
  } flags_t;

  // Returns {is_status, code}. Priority: error, freq, no target, high, low.
  function automatic logic [4:0] classify(input flags_t f, input logic over,
                                          input logic under);
    if (f.err)         return {1'b1, CODE_ERROR};
    else if (f.freq)   return {1'b1, CODE_FREQ};
    else if (f.no_tgt) return {1'b1, CODE_EMPTY};
    else if (over)     return {1'b1, CODE_HIGH};
    else if (under)    return {1'b1, CODE_LOW};
    else               return {1'b0, CODE_0};
  endfunction

endpackage

// File: rtl/speed_bcd_conv.sv
// Iterative binary-to-BCD converter: one subtract-10 step per enabled cycle.
// o_done is combinational so the caller can capture {tens, ones} on the same
// edge the remainder first drops below ten.
module speed_bcd_conv #(
  parameter int SPEED_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_en,
  input  logic [SPEED_W-1:0] i_val,
  output logic               o_done,
  output logic [3:0]         o_tens,
  output logic [3:0]         o_ones
);

  localparam logic [SPEED_W-1:0] TEN = SPEED_W'(10);

  logic [SPEED_W-1:0] r_rem;
  logic [3:0]         r_tens;
  logic               w_done;

  assign w_done = (r_rem < TEN);

  // Load on start, then peel off one ten per cycle while enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_tens <= '0;
    end else if (i_start) begin
      r_rem  <= i_val;
      r_tens <= '0;
    end else if (i_en && !w_done) begin
      r_rem  <= r_rem - TEN;
      r_tens <= r_tens + 4'd1;
    end
  end

  assign o_done = w_done;
  assign o_tens = r_tens;
  assign o_ones = r_rem[3:0];

endmodule

// File: rtl/speed_msg_encoder.sv
// Speed-to-display message encoder: classifies a strobed speed sample, builds
// an 8-bit display message and frames it with a noti pulse followed by a gap.
// Requests arriving while busy are held in a single latest-wins pending slot.
module speed_msg_encoder
  import speed_msg_encoder_pkg::*;
#(
  parameter int SPEED_W = 10,
  parameter int MIN_SPD = 3,
  parameter int MAX_SPD = 99,
  parameter int NOTI_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SPEED_W-1:0] speed_val,
  input  logic               speed_vld,
  input  logic               err_flag,
  input  logic               freq_flag,
  input  logic               no_tgt,
  output logic [7:0]         msg,
  output logic               noti,
  output logic               busy
);

  localparam int                 CNT_W = $clog2(NOTI_W + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(NOTI_W - 1);
  localparam logic [SPEED_W:0]   MAX_V = (SPEED_W+1)'(MAX_SPD);
  localparam logic [SPEED_W:0]   MIN_V = (SPEED_W+1)'(MIN_SPD);

  logic [2:0]         r_state;
  logic [7:0]         r_msg;
  logic               r_noti;
  logic [CNT_W-1:0]   r_cnt;

  logic               r_pend_vld;
  logic [SPEED_W-1:0] r_pend_spd;
  flags_t             r_pend_flg;

  flags_t             w_in_flg;
  logic               w_req_vld;
  logic [SPEED_W-1:0] w_req_spd;
  flags_t             w_req_flg;
  logic               w_over;
  logic               w_under;
  logic [4:0]         w_cls;
  logic               w_is_stat;
  logic [3:0]         w_code;
  logic               w_idle;
  logic               w_conv_start;
  logic               w_conv_done;
  logic [3:0]         w_tens;
  logic [3:0]         w_ones;

  assign w_in_flg = '{err: err_flag, freq: freq_flag, no_tgt: no_tgt};
  assign w_idle   = (r_state == ST_IDLE);

  // The pending slot takes precedence over a fresh strobe in IDLE.
  assign w_req_vld = r_pend_vld | speed_vld;
  assign w_req_spd = r_pend_vld ? r_pend_spd : speed_val;
  assign w_req_flg = r_pend_vld ? r_pend_flg : w_in_flg;

  assign w_over    = ({1'b0, w_req_spd} > MAX_V);
  assign w_under   = ({1'b0, w_req_spd} < MIN_V);
  assign w_cls     = classify(w_req_flg, w_over, w_under);
  assign w_is_stat = w_cls[4];
  assign w_code    = w_cls[3:0];

  assign w_conv_start = w_idle && w_req_vld && !w_is_stat;

  speed_bcd_conv #(
    .SPEED_W (SPEED_W)
  ) u_conv (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_conv_start),
    .i_en    (r_state == ST_CONV),
    .i_val   (w_req_spd),
    .o_done  (w_conv_done),
    .o_tens  (w_tens),
    .o_ones  (w_ones)
  );

  // Pending slot: latch any strobe while busy; in IDLE the slot is consumed,
  // but a strobe landing on that same edge refills it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_vld <= 1'b0;
      r_pend_spd <= '0;
      r_pend_flg <= '0;
    end else if (!w_idle) begin
      if (speed_vld) begin
        r_pend_vld <= 1'b1;
        r_pend_spd <= speed_val;
        r_pend_flg <= w_in_flg;
      end
    end else begin
      r_pend_vld <= r_pend_vld && speed_vld;
      if (r_pend_vld && speed_vld) begin
        r_pend_spd <= speed_val;
        r_pend_flg <= w_in_flg;
      end
    end
  end

  // Main FSM: classify/convert, load msg, then NOTI_W high and NOTI_W low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_msg   <= 8'h00;
      r_noti  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_vld) begin
            if (w_is_stat) begin
              r_msg   <= {w_code, w_code};
              r_state <= ST_LOAD;
            end else begin
              r_state <= ST_CONV;
            end
          end
        end
        ST_CONV: begin
          if (w_conv_done) begin
            r_msg   <= {w_tens, w_ones};
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_noti  <= 1'b1;
          r_cnt   <= '0;
          r_state <= ST_PULSE;
        end
        ST_PULSE: begin
          if (r_cnt == CNT_LAST) begin
            r_noti  <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_noti  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign msg  = r_msg;
  assign noti = r_noti;
  assign busy = !w_idle;

endmodule

// File: doc/speed_msg_encoder.md
SPEED_MSG_ENCODER -- requirements
Module: speed_msg_encoder

Interface
REQ-001 Parameter SPEED_W, default 10: width of the speed input in km/h.
REQ-002 Parameter MIN_SPD, default 3: speeds below this value are reported as LOW.
REQ-003 Parameter MAX_SPD, default 99: speeds above this value are reported as HIGH.
REQ-004 Parameter NOTI_W, default 4: cycles of the noti high phase, and cycles of the following low gap.
REQ-005 Port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 Port speed_val, input, SPEED_W bits: measured speed, binary, in km/h.
REQ-008 Port speed_vld, input, 1 bit: one-cycle strobe; speed_val and the three flags are sampled with it.
REQ-009 Port err_flag, input, 1 bit: measurement error.
REQ-010 Port freq_flag, input, 1 bit: Doppler frequency out of range.
REQ-011 Port no_tgt, input, 1 bit: no target present.
REQ-012 Port msg, output, 8 bits: [7:4] is the left code, [3:0] is the right code, in the display message-code set.
REQ-013 Port noti, output, 1 bit: update pulse; the display samples msg on the rising edge of noti.
REQ-014 Port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 Message codes are 0-9 for digits, A = EMPTY, B = HIGH, C = LOW, D = FREQ, E = ERROR; each status code is sent as the same code in both nibbles (e.g. 0xBB).
REQ-016 Classification priority SHALL be err_flag (0xEE), then freq_flag (0xDD), then no_tgt (0xAA), then speed > MAX_SPD (0xBB), then speed < MIN_SPD (0xCC), otherwise digits.
REQ-017 Digits SHALL be msg = {tens, ones} in BCD; a tens value of 0 is sent as 0, and the display blanks it.
REQ-018 The FSM SHALL have five states: IDLE, CONV, LOAD, PULSE, GAP.
REQ-019 IDLE with a request and a digit result: capture speed_val into the remainder register, clear tens, go to CONV.
REQ-020 IDLE with a request and a status result: write the status code to msg on that edge, go to LOAD.
REQ-021 CONV, remainder >= 10: subtract 10, increment tens, stay in CONV (one subtraction per cycle).
REQ-022 CONV, remainder < 10: write msg = {tens, remainder} on that edge, go to LOAD.
REQ-023 LOAD: on exit, set noti = 1 and go to PULSE; msg is therefore stable one full cycle before noti rises.
REQ-024 PULSE: hold noti = 1 for exactly NOTI_W cycles, then clear noti and go to GAP.
REQ-025 GAP: hold noti = 0 for exactly NOTI_W cycles, then go to IDLE.
REQ-026 msg SHALL NOT change in PULSE or GAP, and SHALL hold its value in IDLE.
REQ-027 Digit latency: strobe sampled at edge E0 gives msg written at E(k+1) and noti rising at E(k+2), where k = tens.
REQ-028 Status latency: msg written at E0 and noti rising at E1.
REQ-029 A speed_vld while busy SHALL be stored in a single pending slot (speed and flags); the latest request wins and older ones are dropped.
REQ-030 IDLE SHALL serve the pending slot before a new strobe; a strobe arriving in the same cycle as the pending slot is served overwrites the slot.
REQ-031 Boundaries: MAX_SPD itself gives digits 99; MAX_SPD+1 gives 0xBB; MIN_SPD-1 gives 0xCC; MIN_SPD gives 0x03.
REQ-032 Boundary: the all-ones speed_val SHALL give 0xBB with no CONV cycles.
REQ-033 Counter widths SHALL hold NOTI_W; the tens register is 4 bits, used only in the digit path where tens <= 9.

Reset
REQ-034 rst high at a rising edge SHALL set state = IDLE, msg = 0x00, noti = 0, busy = 0, clear the pending slot, and zero the counters.
REQ-035 rst asserted mid-PULSE SHALL drop noti on that same edge, and any conversion in progress is discarded.
REQ-036 Flags and strobes sampled during the reset cycle are ignored.

Structure
REQ-037 A shared package SHALL hold the message-code constants (0-9, A-E) and the state encoding, shared with the display decoder.
REQ-038 One sub-module, speed_bcd_conv, SHALL implement the iterative subtract-10 CONV datapath with start, done, tens and ones signals; the top holds the FSM, pending slot and noti timing.

Verification
REQ-039 Scenario: speed 57 strobed at E0 -> msg 0x57 at E6, noti high E7-E10, low E11-E14, busy low from E15.
REQ-040 Scenario: speed 99 -> msg 0x99; speed 100 -> 0xBB; speed 2 -> 0xCC; speed 3 -> 0x03.
REQ-041 Scenario: err_flag, freq_flag and no_tgt all high with speed 50 -> 0xEE, noti rising at E1; freq_flag with no_tgt -> 0xDD.
REQ-042 Scenario: strobes 20, 30, 40 all during PULSE of a prior request -> only 40 is emitted afterwards, and exactly two noti pulses occur in total.
REQ-043 Scenario: rst asserted in the second PULSE cycle -> noti = 0 and msg = 0x00 on the same edge; a following strobe of 8 gives 0x08.
